// File: rtl/race_pkg.sv
// Shared definitions for the race step tracker.
//   SEQ_DEFAULT : default 33-box left/right course (bit i = box i, 1 = right)
//   KEY_LEFT/KEY_RIGHT : key encoding used in the sequence constant
//   step_width  : width of a step counter that must reach seq_len
package race_pkg;

    localparam logic [32:0] SEQ_DEFAULT = 33'h1_2D69_5A3C;

    localparam logic KEY_LEFT  = 1'b0;
    localparam logic KEY_RIGHT = 1'b1;

    // The counter has to hold SEQ_LEN itself (the "finished" box), hence +1.
    function automatic int step_width(input int seq_len);
        return $clog2(seq_len + 1);
    endfunction

endpackage

// File: rtl/race_lane.sv
// One lane of the race tracker: key edge detection, step counter,
// saturating error counter, optional lockout after a wrong press, done flag.
// Ports:
//   clk, resetn      : clock, synchronous active-high reset
//   enable           : game running; presses ignored while low
//   left, right      : debounced level keys for this lane
//   step             : current box index (0..SEQ_LEN)
//   errors           : wrong-press count, saturating
//   done             : lane has reached SEQ_LEN (sticky)
//   locked           : lane is in lockout
//   finishing        : combinational, done will set at the coming edge
module race_lane
    import race_pkg::*;
#(
    parameter int          SEQ_LEN     = 33,
    parameter logic [63:0] SEQ         = 64'(SEQ_DEFAULT),
    parameter int          ERR_W       = 8,
    parameter int          LOCK_CYCLES = 0,
    localparam int         STEP_W      = step_width(SEQ_LEN),
    localparam int         LOCK_W      = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic              left,
    input  logic              right,
    output logic [STEP_W-1:0] step,
    output logic [ERR_W-1:0]  errors,
    output logic              done,
    output logic              locked,
    output logic              finishing
);

    logic              left_q_reg;
    logic              right_q_reg;
    logic [STEP_W-1:0] step_reg,   step_next;
    logic [ERR_W-1:0]  errors_reg, errors_next;
    logic              done_reg,   done_next;
    logic [LOCK_W-1:0] lock_reg,   lock_next;

    logic rise_left;
    logic rise_right;
    logic eligible;
    logic expected_key;
    logic pressed_key;

    always_comb begin
        // Expected key for the current box; a mux loop keeps the index
        // width independent of the sequence vector width.
        expected_key = KEY_LEFT;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (step_reg == STEP_W'(i)) begin
                expected_key = SEQ[i];
            end
        end

        rise_left   = left  & ~left_q_reg;
        rise_right  = right & ~right_q_reg;
        pressed_key = rise_right ? KEY_RIGHT : KEY_LEFT;
        eligible    = enable & ~done_reg & (lock_reg == '0);

        step_next   = step_reg;
        errors_next = errors_reg;
        done_next   = done_reg;
        // Lockout drains every cycle, independent of enable.
        lock_next   = (lock_reg != '0) ? lock_reg - LOCK_W'(1) : lock_reg;

        if (eligible && (rise_left || rise_right)) begin
            if ((rise_left ^ rise_right) && (pressed_key == expected_key)) begin
                step_next = step_reg + STEP_W'(1);
                if (step_reg == STEP_W'(SEQ_LEN - 1)) begin
                    done_next = 1'b1;
                end
            end else begin
                // Wrong key, or both keys in the same cycle.
                if (errors_reg != '1) begin
                    errors_next = errors_reg + ERR_W'(1);
                end
                if (LOCK_CYCLES > 0) begin
                    lock_next = LOCK_W'(LOCK_CYCLES);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // Key history always tracks the levels, including during reset,
        // so a key held through reset release is not seen as a press.
        left_q_reg  <= left;
        right_q_reg <= right;
        if (resetn) begin
            step_reg   <= '0;
            errors_reg <= '0;
            done_reg   <= 1'b0;
            lock_reg   <= '0;
        end else begin
            step_reg   <= step_next;
            errors_reg <= errors_next;
            done_reg   <= done_next;
            lock_reg   <= lock_next;
        end
    end

    assign step      = step_reg;
    assign errors    = errors_reg;
    assign done      = done_reg;
    assign locked    = (lock_reg != '0);
    assign finishing = done_next & ~done_reg;

endmodule

// File: rtl/race_tracker.sv
// Multi-player step tracker for the race game. Instantiates one race_lane
// per player and records which lanes finished first.
// Ports:
//   clk, resetn   : clock, synchronous active-high reset (despite the name)
//   enable        : game running
//   left, right   : per-lane debounced keys
//   step, errors  : per-lane packed counters, lane 0 in the LSBs
//   done, locked  : per-lane flags
//   winner        : lanes that finished in the first finishing cycle
//   winner_valid  : winner has been latched
//   tie           : more than one lane in winner
//   all_done      : every lane finished
module race_tracker
    import race_pkg::*;
#(
    parameter int          NUM_PLAYERS = 2,
    parameter int          SEQ_LEN     = 33,
    parameter logic [63:0] SEQ         = 64'(SEQ_DEFAULT),
    parameter int          ERR_W       = 8,
    parameter int          LOCK_CYCLES = 0,
    localparam int         STEP_W      = step_width(SEQ_LEN)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          enable,
    input  logic [NUM_PLAYERS-1:0]        left,
    input  logic [NUM_PLAYERS-1:0]        right,
    output logic [NUM_PLAYERS*STEP_W-1:0] step,
    output logic [NUM_PLAYERS*ERR_W-1:0]  errors,
    output logic [NUM_PLAYERS-1:0]        done,
    output logic [NUM_PLAYERS-1:0]        locked,
    output logic [NUM_PLAYERS-1:0]        winner,
    output logic                          winner_valid,
    output logic                          tie,
    output logic                          all_done
);

    logic [NUM_PLAYERS-1:0] finishing;
    logic [NUM_PLAYERS-1:0] winner_reg;
    logic                   winner_valid_reg;

    generate
        for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_lane
            race_lane #(
                .SEQ_LEN     (SEQ_LEN),
                .SEQ         (SEQ),
                .ERR_W       (ERR_W),
                .LOCK_CYCLES (LOCK_CYCLES)
            ) u_lane (
                .clk       (clk),
                .resetn    (resetn),
                .enable    (enable),
                .left      (left[gi]),
                .right     (right[gi]),
                .step      (step[gi*STEP_W +: STEP_W]),
                .errors    (errors[gi*ERR_W +: ERR_W]),
                .done      (done[gi]),
                .locked    (locked[gi]),
                .finishing (finishing[gi])
            );
        end
    endgenerate

    // Winner is latched once, at the same edge the first done bit(s) set.
    always_ff @(posedge clk) begin
        if (resetn) begin
            winner_reg       <= '0;
            winner_valid_reg <= 1'b0;
        end else if (!winner_valid_reg && (finishing != '0)) begin
            winner_reg       <= finishing;
            winner_valid_reg <= 1'b1;
        end
    end

    assign winner       = winner_reg;
    assign winner_valid = winner_valid_reg;
    // x & (x-1) clears the lowest set bit; non-zero means two or more bits.
    assign tie          = winner_valid_reg &&
                          ((winner_reg & (winner_reg - NUM_PLAYERS'(1))) != '0);
    assign all_done     = &done;

endmodule

// File: tb/tb_race_tracker.sv
module tb_race_tracker;

    localparam int NP     = 2;
    localparam int SLEN   = 4;
    localparam int STEP_W = 3;
    localparam int ERR_W  = 8;

    logic                   clk;
    logic                   resetn;
    logic                   enable;
    logic [NP-1:0]          left;
    logic [NP-1:0]          right;
    logic [NP*STEP_W-1:0]   step;
    logic [NP*ERR_W-1:0]    errors;
    logic [NP-1:0]          done;
    logic [NP-1:0]          locked;
    logic [NP-1:0]          winner;
    logic                   winner_valid;
    logic                   tie;
    logic                   all_done;

    int tests_run = 0;
    int tests_failed = 0;

    race_tracker #(
        .NUM_PLAYERS (NP),
        .SEQ_LEN     (SLEN),
        .SEQ         (64'b1001),
        .ERR_W       (ERR_W),
        .LOCK_CYCLES (3)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (enable),
        .left         (left),
        .right        (right),
        .step         (step),
        .errors       (errors),
        .done         (done),
        .locked       (locked),
        .winner       (winner),
        .winner_valid (winner_valid),
        .tie          (tie),
        .all_done     (all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, got);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle rise on the selected keys, then release.
    task automatic press(input logic [NP-1:0] l, input logic [NP-1:0] r);
        left  = l;
        right = r;
        cycle();
        left  = '0;
        right = '0;
        cycle();
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        cycle();
        cycle();
        resetn = 1'b0;
    endtask

    function automatic int unsigned step_of(input int lane);
        return int'(step[lane*STEP_W +: STEP_W]);
    endfunction

    function automatic int unsigned err_of(input int lane);
        return int'(errors[lane*ERR_W +: ERR_W]);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_step"},   int'(step),   0);
        check({tag, "_errors"}, int'(errors), 0);
        check({tag, "_done"},   int'(done),   0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_winner"}, int'(winner), 0);
        check({tag, "_wvalid"}, int'(winner_valid), 0);
        check({tag, "_tie"},    int'(tie),    0);
        check({tag, "_alldone"}, int'(all_done), 0);
    endtask

    initial begin
        resetn = 1'b1;
        enable = 1'b0;
        left   = '0;
        right  = '0;
        do_reset();
        check_all_zero("reset");
        enable = 1'b1;

        // Lane 0 runs the course R, L, L, R.
        press(2'b00, 2'b01);
        check("l0_step1", step_of(0), 1);
        press(2'b01, 2'b00);
        check("l0_step2", step_of(0), 2);
        press(2'b01, 2'b00);
        check("l0_step3", step_of(0), 3);
        check("l0_nodone3", int'(done), 0);
        press(2'b00, 2'b01);
        check("l0_step4", step_of(0), 4);
        check("l0_done", int'(done), 1);
        check("win_lane0", int'(winner), 1);
        check("win_valid", int'(winner_valid), 1);
        check("win_notie", int'(tie), 0);
        check("alldone_partial", int'(all_done), 0);
        // Further presses do not move a done lane.
        press(2'b00, 2'b01);
        check("l0_step_hold", step_of(0), 4);

        // Lane 1: wrong key at step 0, then lockout behaviour.
        left = 2'b10;
        cycle();
        check("l1_err1", err_of(1), 1);
        check("l1_locked_a", int'(locked[1]), 1);
        left  = 2'b00;
        right = 2'b10;
        cycle();
        check("l1_ign_step", step_of(1), 0);
        check("l1_ign_err", err_of(1), 1);
        check("l1_locked_b", int'(locked[1]), 1);
        right = 2'b00;
        cycle();
        check("l1_locked_c", int'(locked[1]), 1);
        cycle();
        check("l1_unlocked", int'(locked[1]), 0);
        press(2'b00, 2'b10);
        check("l1_step_after", step_of(1), 1);
        check("l1_err_after", err_of(1), 1);
        check("win_unchanged", int'(winner), 1);

        // Holding R on lane 0 for 10 cycles counts once.
        do_reset();
        check_all_zero("rst2");
        right = 2'b01;
        repeat (10) cycle();
        check("hold_step", step_of(0), 1);
        check("hold_err", err_of(0), 0);
        right = 2'b00;
        cycle();

        // Both keys rise together at step 1: error, no step change.
        press(2'b01, 2'b01);
        check("both_err", err_of(0), 1);
        check("both_step", step_of(0), 1);
        check("both_locked", int'(locked[0]), 1);
        repeat (4) cycle();

        // Both lanes finish on the same edge.
        do_reset();
        press(2'b00, 2'b11);
        press(2'b11, 2'b00);
        press(2'b11, 2'b00);
        check("tie_nowin", int'(winner_valid), 0);
        press(2'b00, 2'b11);
        check("tie_winner", int'(winner), 3);
        check("tie_flag", int'(tie), 1);
        check("tie_alldone", int'(all_done), 1);

        // Mid-game reset with R held through the release.
        right  = 2'b01;
        resetn = 1'b1;
        cycle();
        cycle();
        resetn = 1'b0;
        check_all_zero("midrst");
        cycle();
        cycle();
        check("midrst_held", step_of(0), 0);
        right = 2'b00;
        cycle();
        check("midrst_rel", step_of(0), 0);
        press(2'b00, 2'b01);
        check("midrst_press", step_of(0), 1);

        // Enable low freezes the step counter.
        enable = 1'b0;
        press(2'b01, 2'b00);
        check("dis_step", step_of(0), 1);
        check("dis_err", err_of(0), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
